// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM encoding, field widths
// and the default decoded word-address width of the data memory.
package lsu_pkg;

  localparam int unsigned LSU_ADDR_BITS = 3;
  localparam int unsigned LSU_DATA_W    = 16;
  localparam int unsigned LSU_TAG_W     = 3;
  localparam int unsigned LSU_CNT_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/sat_counter.sv
// Event counter with enable that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: captures one request, performs a
// one-cycle memory access, then holds the response until writeback takes it.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_BITS = LSU_ADDR_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [LSU_DATA_W-1:0] req_addr,
  input  logic [LSU_DATA_W-1:0] req_wdata,
  input  logic [LSU_TAG_W-1:0]  req_rd,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [LSU_DATA_W-1:0] resp_rdata,
  output logic [LSU_TAG_W-1:0]  resp_rd,
  output logic                  resp_we,
  output logic                  resp_err,
  output logic                  mem_write_en,
  output logic                  mem_read_en,
  output logic [LSU_DATA_W-1:0] mem_access_addr,
  output logic [LSU_DATA_W-1:0] mem_write_data,
  input  logic [LSU_DATA_W-1:0] mem_read_data,
  output logic [LSU_CNT_W-1:0]  load_cnt,
  output logic [LSU_CNT_W-1:0]  store_cnt,
  output logic [LSU_CNT_W-1:0]  err_cnt
);

  lsu_state_e r_state;
  lsu_state_e w_next_state;

  logic                  r_we;
  logic                  r_err;
  logic [LSU_DATA_W-1:0] r_addr;
  logic [LSU_DATA_W-1:0] r_wdata;
  logic [LSU_TAG_W-1:0]  r_rd;

  logic [LSU_DATA_W-1:0] r_resp_rdata;
  logic [LSU_TAG_W-1:0]  r_resp_rd;
  logic                  r_resp_we;
  logic                  r_resp_err;

  logic w_req_hs;
  logic w_addr_err;
  logic w_in_access;
  logic w_load_en;
  logic w_store_en;
  logic w_err_en;

  assign w_addr_err = (req_addr >> ADDR_BITS) != '0;
  assign w_req_hs   = req_valid & req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (req_valid)  w_next_state = ST_ACCESS;
      ST_ACCESS:                 w_next_state = ST_RESP;
      ST_RESP:   if (resp_ready) w_next_state = ST_IDLE;
      default:                   w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    w_in_access  = 1'b0;
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;
    w_load_en    = 1'b0;
    w_store_en   = 1'b0;
    w_err_en     = 1'b0;
    case (r_state)
      ST_IDLE:   req_ready  = 1'b1;
      ST_ACCESS: begin
        w_in_access  = 1'b1;
        mem_write_en = r_we & ~r_err;
        mem_read_en  = ~r_we & ~r_err;
        w_load_en    = ~r_we & ~r_err;
        w_store_en   = r_we & ~r_err;
        w_err_en     = r_err;
      end
      ST_RESP:   resp_valid = 1'b1;
      default:   req_ready  = 1'b0;
    endcase
  end

  // Captured fields double as the memory address/data bus, so the bus holds
  // its last value outside ACCESS without extra registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rd    <= '0;
    end else if (w_req_hs) begin
      r_we    <= req_we;
      r_err   <= w_addr_err;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_rd    <= req_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_rdata <= '0;
      r_resp_rd    <= '0;
      r_resp_we    <= 1'b0;
      r_resp_err   <= 1'b0;
    end else if (w_in_access) begin
      r_resp_rdata <= w_load_en ? mem_read_data : '0;
      r_resp_rd    <= r_rd;
      r_resp_we    <= r_we;
      r_resp_err   <= r_err;
    end
  end

  assign mem_access_addr = r_addr;
  assign mem_write_data  = r_wdata;
  assign resp_rdata      = r_resp_rdata;
  assign resp_rd         = r_resp_rd;
  assign resp_we         = r_resp_we;
  assign resp_err        = r_resp_err;

  sat_counter #(.WIDTH(LSU_CNT_W)) u_load_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_load_en),
    .o_cnt (load_cnt)
  );

  sat_counter #(.WIDTH(LSU_CNT_W)) u_store_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_store_en),
    .o_cnt (store_cnt)
  );

  sat_counter #(.WIDTH(LSU_CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_err_en),
    .o_cnt (err_cnt)
  );

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 3, giving the number of word-address bits decoded by the data memory (8 words).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  execute stage presents a memory request.
REQ-005 SHALL have port req_ready  output  1  unit accepts a request this cycle.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_addr  input  16  word address.
REQ-008 SHALL have port req_wdata  input  16  store data.
REQ-009 SHALL have port req_rd  input  3  load destination register tag, returned unchanged.
REQ-010 SHALL have port resp_valid  output  1  response available for writeback.
REQ-011 SHALL have port resp_ready  input  1  writeback stage consumes the response.
REQ-012 SHALL have port resp_rdata  output  16  load data (0 for stores and errors).
REQ-013 SHALL have port resp_rd  output  3  tag of the completed request.
REQ-014 SHALL have port resp_we  output  1  completed request was a store.
REQ-015 SHALL have port resp_err  output  1  address out of range; memory untouched.
REQ-016 SHALL have ports mem_write_en, mem_read_en (output 1), mem_access_addr, mem_write_data (output 16) and mem_read_data (input 16), driving the data memory.
REQ-017 SHALL have ports load_cnt, store_cnt, err_cnt  output  16  saturating event counters.

Function
REQ-018 SHALL implement the states IDLE, ACCESS and RESP.
REQ-019 SHALL drive req_ready = 1 only in IDLE; a handshake (req_valid & req_ready) at an edge SHALL capture we/addr/wdata/rd and move to ACCESS.
REQ-020 SHALL flag error when req_addr[15:ADDR_BITS] != 0; the flag is computed at capture.
REQ-021 SHALL, in ACCESS, drive mem_access_addr/mem_write_data from the captured values, with mem_write_en = we & !err and mem_read_en = !we & !err, for exactly one cycle.
REQ-022 SHALL, at the edge ending ACCESS, register mem_read_data into resp_rdata for a valid load (0 otherwise), update the counters, and enter RESP.
REQ-023 SHALL hold resp_valid = 1 with stable resp_* fields in RESP until resp_ready = 1, then return to IDLE at that edge.
REQ-024 SHALL hold mem strobes at 0 and mem_access_addr/mem_write_data at their last values outside ACCESS.
REQ-025 SHALL give a latency of exactly 2 edges from handshake to resp_valid, and a minimum of 3 cycles per request.
REQ-026 SHALL count one of load_cnt, store_cnt or err_cnt per request; an errored request increments only err_cnt; each counter saturates at 0xFFFF.
REQ-027 SHALL ignore req_* inputs outside IDLE.

Reset
REQ-028 SHALL, on rst_n low, immediately enter IDLE and clear all of the following: resp_valid, resp_rdata, resp_rd, resp_we, resp_err, the mem strobes, mem_access_addr, mem_write_data and all counters; req_ready is 1 after reset.
REQ-029 SHALL drop an in-flight request (including a pending store) if reset asserts during ACCESS or RESP, with no memory write.

Structure
REQ-030 SHALL take state encodings and the ADDR_BITS default from a shared lsu_pkg.
REQ-031 SHALL instantiate the three counters from one sub-module, sat_counter (16-bit, enable, saturating).

Verification
REQ-032 SHALL test that a store to addr 0x0005 with data 0xBEEF gives mem_write_en high for one cycle with addr 5; resp_we=1, resp_err=0 two edges after the handshake; store_cnt=1.
REQ-033 SHALL test that a load of addr 0x0005 after that store, with rd=3, gives resp_rdata=0xBEEF, resp_rd=3, load_cnt=1.
REQ-034 SHALL test that a store to addr 0x0008 gives resp_err=1, mem_write_en never high, resp_rdata=0, err_cnt=1, store_cnt unchanged.
REQ-035 SHALL test that with resp_ready held 0 for 4 cycles, resp fields stay stable, req_ready stays 0, and a new req_valid is ignored until the response is taken.
REQ-036 SHALL test that reset during ACCESS of a store to addr 2 with data 0x1234 leaves memory word 2 unchanged, all outputs 0, and req_ready=1.
REQ-037 SHALL test that with load_cnt preset near 0xFFFF via repeated loads, the counter sticks at 0xFFFF.
